// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC accumulator slice.
//   - mac_state_e   : control FSM states
//   - OP_W / PROD_W : operand and product widths of the 8x8 signed multiplier
//   - sign_ext_prod : sign-extends a product to 64 bits; callers truncate to
//                     their accumulator width with a size cast
package mac_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        ACCUM,
        DONE,
        DRAIN
    } mac_state_e;

    function automatic logic [63:0] sign_ext_prod(input logic [PROD_W-1:0] p);
        return {{(64-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: operand-pair stream into the MAC accumulator.
//   in_valid : pair valid            (master -> slave)
//   in_ready : slave can accept pair (slave  -> master)
//   in_a     : signed operand A      (master -> slave)
//   in_b     : signed operand B      (master -> slave)
//   in_last  : pair ends the frame   (master -> slave)
interface mac_accumulator_if;
    import mac_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_a;
    logic [OP_W-1:0] in_b;
    logic            in_last;

    modport master (output in_valid, output in_a, output in_b, output in_last,
                    input  in_ready);
    modport slave  (input  in_valid, input  in_a, input  in_b, input  in_last,
                    output in_ready);
endinterface

// File: rtl/mac_acc_add.sv
// mac_acc_add: combinational accumulate step.
//   acc_i  : current accumulator (ACC_W, signed)
//   prod_i : signed 16-bit product to add
//   sum_o  : next accumulator value
//   ovf_o  : signed overflow of this add
// Build option MAC_SAT_EN: when defined, an overflowing add clamps to the most
// positive / most negative ACC_W value according to the addend sign; when
// undefined the sum wraps in two's complement. ovf_o is reported either way.
module mac_acc_add
    import mac_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] raw_sum;
`ifdef MAC_SAT_EN
    logic [ACC_W-1:0] sat_val;
`endif

    always_comb begin
        addend  = ACC_W'(sign_ext_prod(prod_i));
        raw_sum = acc_i + addend;
        // Overflow only when both operands share a sign that the sum lacks.
        ovf_o   = (acc_i[ACC_W-1] == addend[ACC_W-1]) &&
                  (raw_sum[ACC_W-1] != acc_i[ACC_W-1]);
        sum_o   = raw_sum;
`ifdef MAC_SAT_EN
        sat_val = '1;
        sat_val[ACC_W-1] = 1'b0;
        if (addend[ACC_W-1]) begin
            sat_val = '0;
            sat_val[ACC_W-1] = 1'b1;
        end
        if (ovf_o) begin
            sum_o = sat_val;
        end
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: dot-product stage in front of a sequential signed 8x8
// multiplier. Each accepted operand pair is issued to the multiplier, the
// product is sign-extended and accumulated; a frame ends on in_last and
// yields one acc_valid pulse.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous frame abort (zeroes acc/count/overflow)
//   in_if        : operand-pair stream (slave side)
//   mul_start    : one-cycle start pulse to multiplier
//   mul_a, mul_b : operands to multiplier, stable between issues
//   mul_product  : signed product from multiplier
//   mul_ready    : multiplier result valid / idle
//   acc_out      : signed accumulated result (ACC_W)
//   acc_valid    : one-cycle pulse, acc_out is a final frame result
//   count        : pairs accumulated in current/last frame (wraps)
//   overflow     : sticky signed-overflow flag for current/last frame
// Build option MAC_SAT_EN selects saturating accumulation (see mac_acc_add).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    mac_accumulator_if.slave  in_if,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_product,
    input  logic              mul_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    mac_state_e        state_q, state_d;
    logic              in_ready_q;
    logic              accept;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic              last_q, last_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              newf_q, newf_d;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;

    mac_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i  (acc_q),
        .prod_i (prod_q),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    // Next-state logic; clear overrides acceptance and normal sequencing.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_if.in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = GUARD;
            GUARD:   state_d = WAIT;
            WAIT:    if (mul_ready) state_d = ACCUM;
            ACCUM:   state_d = last_q ? DONE : IDLE;
            DONE:    state_d = IDLE;
            DRAIN:   if (mul_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            accept = 1'b0;
            case (state_q)
                ISSUE, GUARD, WAIT: state_d = DRAIN;
                // A drain already in progress must still absorb the
                // outstanding product before new work is issued.
                DRAIN:   state_d = state_d;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next-state.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        last_d = last_q;
        prod_d = prod_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        newf_d = newf_q;
        if (accept) begin
            a_d    = in_if.in_a;
            b_d    = in_if.in_b;
            last_d = in_if.in_last;
            // Results of the finished frame stay visible until the next
            // frame's first pair is taken.
            if (newf_q) begin
                acc_d  = '0;
                cnt_d  = '0;
                ovf_d  = 1'b0;
                newf_d = 1'b0;
            end
        end
        if (state_q == WAIT && mul_ready) begin
            prod_d = mul_product;
        end
        if (state_q == ACCUM) begin
            acc_d = add_sum;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
        end
        if (state_q == DONE) begin
            newf_d = 1'b1;
        end
        if (clear) begin
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            newf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            last_q     <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            newf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered so that in_ready reads 0 while held in reset.
            in_ready_q <= (state_d == IDLE);
            a_q        <= a_d;
            b_q        <= b_d;
            last_q     <= last_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            newf_q     <= newf_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign mul_start      = (state_q == ISSUE);
    assign mul_a          = a_q;
    assign mul_b          = b_q;
    assign acc_out        = acc_q;
    assign acc_valid      = (state_q == DONE) && !clear;
    assign count          = cnt_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    logic       tb_valid = 1'b0;
    logic       tb_last  = 1'b0;
    logic [7:0] tb_a     = 8'h00;
    logic [7:0] tb_b     = 8'h00;

    mac_accumulator_if if24();
    mac_accumulator_if if16();

    assign if24.in_valid = tb_valid;
    assign if24.in_a     = tb_a;
    assign if24.in_b     = tb_b;
    assign if24.in_last  = tb_last;
    assign if16.in_valid = tb_valid;
    assign if16.in_a     = tb_a;
    assign if16.in_b     = tb_b;
    assign if16.in_last  = tb_last;

    // Behavioural multiplier shared by both instances (they run in lock-step).
    logic        m_ready;
    logic [15:0] m_prod;
    logic [7:0]  m_a, m_b;
    int          m_cnt;

    logic        st24, st16, av24, av16, ov24, ov16;
    logic [7:0]  ma24, mb24, ma16, mb16, cnt24, cnt16;
    logic [23:0] acc24;
    logic [15:0] acc16;

    mac_accumulator #(.ACC_W(24), .CNT_W(8)) u24 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(if24),
        .mul_start(st24), .mul_a(ma24), .mul_b(mb24),
        .mul_product(m_prod), .mul_ready(m_ready),
        .acc_out(acc24), .acc_valid(av24), .count(cnt24), .overflow(ov24)
    );

    mac_accumulator #(.ACC_W(16), .CNT_W(8)) u16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(if16),
        .mul_start(st16), .mul_a(ma16), .mul_b(mb16),
        .mul_product(m_prod), .mul_ready(m_ready),
        .acc_out(acc16), .acc_valid(av16), .count(cnt16), .overflow(ov16)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_prod  <= 16'h0000;
            m_a     <= 8'h00;
            m_b     <= 8'h00;
            m_cnt   <= 0;
        end else if (st24) begin
            m_ready <= 1'b0;
            m_cnt   <= 3;
            m_a     <= ma24;
            m_b     <= mb24;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                m_prod  <= $signed({{8{m_a[7]}}, m_a}) * $signed({{8{m_b[7]}}, m_b});
            end
        end
    end

    // Event monitors.
    int          n_start = 0, n_av24 = 0, n_av16 = 0, n_acc = 0;
    logic [7:0]  cap_ma = 8'h00, cap_mb = 8'h00, cap_cnt24 = 8'h00, cap_cnt16 = 8'h00;
    logic [23:0] cap_acc24 = 24'h0;
    logic [15:0] cap_acc16 = 16'h0;
    logic        cap_ov24 = 1'b0, cap_ov16 = 1'b0;

    always @(negedge clk) begin
        if (st24) begin
            n_start = n_start + 1;
            cap_ma  = ma24;
            cap_mb  = mb24;
        end
        if (av24) begin
            n_av24    = n_av24 + 1;
            cap_acc24 = acc24;
            cap_cnt24 = cnt24;
            cap_ov24  = ov24;
        end
        if (av16) begin
            n_av16    = n_av16 + 1;
            cap_acc16 = acc16;
            cap_cnt16 = cnt16;
            cap_ov16  = ov16;
        end
    end

    always @(posedge clk) begin
        if (tb_valid && if24.in_ready) n_acc = n_acc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l, input logic hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!if24.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", if24.in_ready);
        end
        tb_a = a; tb_b = b; tb_last = l; tb_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tb_valid = 1'b0;
    endtask

    task automatic wait_av(input int n0);
        int n;
        n = 0;
        while (n_av24 == n0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL acc_valid_timeout pulses=%0d required=%0d", n_av24 - n0, 1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (if24.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", if24.in_ready); end
        checks++;
        if ({st24, av24, ov24} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {st24, av24, ov24}); end
        checks++;
        if ({ma24, mb24, cnt24} !== 24'h0) begin errors++; $display("FAIL reset_regs got=%h exp=000000", {ma24, mb24, cnt24}); end
        checks++;
        if (acc24 !== 24'h0) begin errors++; $display("FAIL reset_acc got=%h exp=000000", acc24); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if24.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%0b exp=1", if24.in_ready); end
    endtask

    task automatic test_single();
        int s0, a0;
        s0 = n_start; a0 = n_av24;
        send(8'h03, 8'hFC, 1'b1, 1'b0);
        checks++;
        if (st24 !== 1'b1) begin errors++; $display("FAIL start_latency got=%0b exp=1", st24); end
        wait_av(a0);
        checks++;
        if (n_start - s0 != 1) begin errors++; $display("FAIL single_starts got=%0d exp=1", n_start - s0); end
        checks++;
        if ({cap_ma, cap_mb} !== 16'h03FC) begin errors++; $display("FAIL single_mul_ops got=%h exp=03fc", {cap_ma, cap_mb}); end
        checks++;
        if (cap_acc24 !== 24'hFFFFF4) begin errors++; $display("FAIL single_acc got=%h exp=fffff4", cap_acc24); end
        checks++;
        if ({cap_cnt24, cap_ov24} !== {8'd1, 1'b0}) begin errors++; $display("FAIL single_cnt_ovf got=%0d/%0b exp=1/0", cap_cnt24, cap_ov24); end
        checks++;
        if (n_av24 - a0 != 1) begin errors++; $display("FAIL single_valid_pulses got=%0d exp=1", n_av24 - a0); end
    endtask

    task automatic test_four_pairs();
        int s0, a0, c0;
        s0 = n_start; a0 = n_av24; c0 = n_acc;
        for (int i = 0; i < 3; i++) send(8'd127, 8'd127, 1'b0, 1'b1);
        send(8'd127, 8'd127, 1'b1, 1'b0);
        wait_av(a0);
        checks++;
        if (cap_acc24 !== 24'h00FC04) begin errors++; $display("FAIL four_acc got=%h exp=00fc04", cap_acc24); end
        checks++;
        if (cap_cnt24 !== 8'd4) begin errors++; $display("FAIL four_count got=%0d exp=4", cap_cnt24); end
        checks++;
        if (n_start - s0 != 4) begin errors++; $display("FAIL four_starts got=%0d exp=4", n_start - s0); end
        checks++;
        if (n_acc - c0 != 4) begin errors++; $display("FAIL four_accepts got=%0d exp=4", n_acc - c0); end
        checks++;
        if (n_av24 - a0 != 1) begin errors++; $display("FAIL four_valid_pulses got=%0d exp=1", n_av24 - a0); end
    endtask

    task automatic test_overflow();
        int a0;
        logic [15:0] exp16;
`ifdef MAC_SAT_EN
        exp16 = 16'h7FFF;
`else
        exp16 = 16'hBD03;
`endif
        a0 = n_av24;
        for (int i = 0; i < 2; i++) send(8'd127, 8'd127, 1'b0, 1'b1);
        send(8'd127, 8'd127, 1'b1, 1'b0);
        wait_av(a0);
        checks++;
        if (cap_acc16 !== exp16) begin errors++; $display("FAIL ovf16_acc got=%h exp=%h", cap_acc16, exp16); end
        checks++;
        if ({cap_ov16, cap_cnt16} !== {1'b1, 8'd3}) begin errors++; $display("FAIL ovf16_flag_cnt got=%0b/%0d exp=1/3", cap_ov16, cap_cnt16); end
        checks++;
        if ({cap_acc24, cap_ov24} !== {24'h00BD03, 1'b0}) begin errors++; $display("FAIL ovf24_acc got=%h/%0b exp=00bd03/0", cap_acc24, cap_ov24); end
    endtask

    task automatic test_clear();
        int a0, n;
        a0 = n_av24;
        send(8'd5, 8'd5, 1'b0, 1'b0);
        send(8'd6, 8'd6, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if ({if24.in_ready, m_ready} !== 2'b00) begin errors++; $display("FAIL clear_drain_ready got=%b exp=00", {if24.in_ready, m_ready}); end
        checks++;
        if ({acc24, cnt24, ov24} !== 33'h0) begin errors++; $display("FAIL clear_zero got=%h/%0d/%0b exp=0/0/0", acc24, cnt24, ov24); end
        n = 0;
        while (!if24.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({if24.in_ready, m_ready} !== 2'b11) begin errors++; $display("FAIL clear_resume got=%b exp=11", {if24.in_ready, m_ready}); end
        checks++;
        if (n_av24 != a0) begin errors++; $display("FAIL clear_no_valid got=%0d exp=0", n_av24 - a0); end
        send(8'h80, 8'h80, 1'b1, 1'b0);
        wait_av(a0);
        checks++;
        if ({cap_acc24, cap_cnt24} !== {24'h004000, 8'd1}) begin errors++; $display("FAIL clear_next_frame got=%h/%0d exp=004000/1", cap_acc24, cap_cnt24); end
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = n_av24;
        send(8'd2, 8'd3, 1'b1, 1'b0);
        wait_av(a0);
        checks++;
        if ({cap_acc24, cap_cnt24} !== {24'h000006, 8'd1}) begin errors++; $display("FAIL b2b_frame1 got=%h/%0d exp=000006/1", cap_acc24, cap_cnt24); end
        a0 = n_av24;
        send(8'hFB, 8'd7, 1'b1, 1'b0);
        wait_av(a0);
        checks++;
        if ({cap_acc24, cap_cnt24} !== {24'hFFFFDD, 8'd1}) begin errors++; $display("FAIL b2b_frame2 got=%h/%0d exp=ffffdd/1", cap_acc24, cap_cnt24); end
        checks++;
        if (n_av24 - a0 != 1) begin errors++; $display("FAIL b2b_valid_pulses got=%0d exp=1", n_av24 - a0); end
    endtask

    task automatic test_reset_mid();
        int a0;
        send(8'd1, 8'd1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if24.in_ready, st24, av24, ov24} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got=%b exp=0000", {if24.in_ready, st24, av24, ov24}); end
        checks++;
        if ({ma24, mb24, cnt24, acc24} !== 48'h0) begin errors++; $display("FAIL rstmid_regs got=%h exp=0", {ma24, mb24, cnt24, acc24}); end
        @(negedge clk);
        rst_n = 1'b1;
        a0 = n_av24;
        send(8'd10, 8'd10, 1'b1, 1'b0);
        wait_av(a0);
        checks++;
        if ({cap_acc24, cap_cnt24} !== {24'd100, 8'd1}) begin errors++; $display("FAIL rstmid_next got=%h/%0d exp=000064/1", cap_acc24, cap_cnt24); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_four_pairs();
        test_overflow();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
